// File: rtl/openframe_gpio_config_pkg.sv
// rtl/openframe_gpio_config_pkg.sv - shared constants, state type and helpers for the pad-configuration stage
// Contents: pad/config geometry, config-word bit positions, cfg_count width,
// commit FSM state type and a saturating counter helper.
package openframe_gpio_pkg;

    localparam int NUM_PADS   = 44;
    localparam int CFG_BITS   = 8;
    localparam int TOTAL_BITS = NUM_PADS * CFG_BITS;
    localparam int COUNT_W    = 9;

    // Bit positions inside one pad's configuration word
    localparam int CFG_OE       = 0;
    localparam int CFG_IE       = 1;
    localparam int CFG_SCHMITT  = 2;
    localparam int CFG_SLEW     = 3;
    localparam int CFG_PULLUP   = 4;
    localparam int CFG_PULLDOWN = 5;
    localparam int CFG_DRIVE0   = 6;
    localparam int CFG_DRIVE1   = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    // Bit counter that sticks at all-ones so an overlong stream never wraps
    // back to a value that looks like a valid length.
    function automatic logic [COUNT_W-1:0] count_inc(input logic [COUNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/openframe_gpio_config_if.sv
// rtl/openframe_gpio_config_if.sv - serial config inputs and pad-control outputs bundle
// Ports (signals): ser_clk/ser_data/ser_strobe async serial inputs, user_out core data,
// gpio_out and the eight gpio_* pad-control vectors, cfg_busy/cfg_error/cfg_count status.
// master: the driver of the serial stream and user_out; slave: the config stage.
interface openframe_gpio_config_if #(
    parameter int NUM_PADS = 44
);
    logic                                   ser_clk;
    logic                                   ser_data;
    logic                                   ser_strobe;
    logic [NUM_PADS-1:0]                    user_out;
    logic [NUM_PADS-1:0]                    gpio_out;
    logic [NUM_PADS-1:0]                    gpio_oe;
    logic [NUM_PADS-1:0]                    gpio_ie;
    logic [NUM_PADS-1:0]                    gpio_schmitt;
    logic [NUM_PADS-1:0]                    gpio_slew;
    logic [NUM_PADS-1:0]                    gpio_pullup;
    logic [NUM_PADS-1:0]                    gpio_pulldown;
    logic [NUM_PADS-1:0]                    gpio_drive0;
    logic [NUM_PADS-1:0]                    gpio_drive1;
    logic                                   cfg_busy;
    logic                                   cfg_error;
    logic [openframe_gpio_pkg::COUNT_W-1:0] cfg_count;

    modport master (
        output ser_clk, ser_data, ser_strobe, user_out,
        input  gpio_out, gpio_oe, gpio_ie, gpio_schmitt, gpio_slew,
               gpio_pullup, gpio_pulldown, gpio_drive0, gpio_drive1,
               cfg_busy, cfg_error, cfg_count
    );

    modport slave (
        input  ser_clk, ser_data, ser_strobe, user_out,
        output gpio_out, gpio_oe, gpio_ie, gpio_schmitt, gpio_slew,
               gpio_pullup, gpio_pulldown, gpio_drive0, gpio_drive1,
               cfg_busy, cfg_error, cfg_count
    );

endinterface

// File: rtl/openframe_gpio_config_sync_edge.sv
// rtl/openframe_gpio_config_sync_edge.sv - multi-flop synchronizer with registered rising-edge pulse
// Ports: clock, resetb (sync active-low), i_async (pad input),
// o_sync (synchronized level, aligned with o_rise), o_rise (one-cycle rising-edge pulse).
module openframe_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    // r_prev holds the same sample that produced r_rise, so a data line
    // taken from o_sync lines up with the shift-clock pulse.
    assign o_sync = r_prev;
    assign o_rise = r_rise;

endmodule

// File: rtl/openframe_gpio_config.sv
// rtl/openframe_gpio_config.sv - serially loaded, strobe-committed GPIO pad configuration
// Ports: clock, resetb (sync active-low), bus (slave modport): serial stream in,
// user_out in, gpio_out and gpio_* pad controls out, cfg_busy/cfg_error/cfg_count status.
module openframe_gpio_config #(
    parameter int                    NUM_PADS     = 44,
    parameter int                    CFG_BITS     = 8,
    parameter int                    SYNC_STAGES  = 2,
    parameter logic [CFG_BITS-1:0]   RESET_CFG    = 8'h02,
    parameter logic [NUM_PADS-1:0]   PROTECT_MASK = '0
) (
    input  logic                   clock,
    input  logic                   resetb,
    openframe_gpio_config_if.slave bus
);

    import openframe_gpio_pkg::*;

    localparam int                 TOT        = NUM_PADS * CFG_BITS;
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(TOT);

    logic w_clk_rise;
    logic w_clk_sync;
    logic w_data_sync;
    logic w_data_rise;
    logic w_strobe_rise;
    logic w_strobe_sync;
    logic w_unused_sync;

    openframe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clock  (clock),
        .resetb (resetb),
        .i_async(bus.ser_clk),
        .o_sync (w_clk_sync),
        .o_rise (w_clk_rise)
    );

    openframe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clock  (clock),
        .resetb (resetb),
        .i_async(bus.ser_data),
        .o_sync (w_data_sync),
        .o_rise (w_data_rise)
    );

    openframe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_strobe (
        .clock  (clock),
        .resetb (resetb),
        .i_async(bus.ser_strobe),
        .o_sync (w_strobe_sync),
        .o_rise (w_strobe_rise)
    );

    assign w_unused_sync = w_clk_sync | w_data_rise | w_strobe_sync;

    cfg_state_t         r_state;
    logic [TOT-1:0]     r_shadow;
    logic [TOT-1:0]     r_active;
    logic [COUNT_W-1:0] r_count;
    logic               r_error;

    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_state  <= IDLE;
            r_shadow <= {NUM_PADS{RESET_CFG}};
            r_active <= {NUM_PADS{RESET_CFG}};
            r_count  <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, SHIFT: begin
                    // Strobe takes priority; a coincident shift pulse is dropped.
                    if (w_strobe_rise) begin
                        r_state <= COMMIT;
                    end else if (w_clk_rise) begin
                        r_shadow <= {r_shadow[TOT-2:0], w_data_sync};
                        r_count  <= count_inc(r_count);
                        r_state  <= SHIFT;
                    end
                end
                COMMIT: begin
                    // Only an exact-length stream may reach the pads.
                    if (r_count == FULL_COUNT) begin
                        r_active <= r_shadow;
                        r_error  <= 1'b0;
                    end else begin
                        r_error  <= 1'b1;
                    end
                    r_count <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic [NUM_PADS-1:0] w_oe;
    logic [NUM_PADS-1:0] w_ie;
    logic [NUM_PADS-1:0] w_schmitt;
    logic [NUM_PADS-1:0] w_slew;
    logic [NUM_PADS-1:0] w_pullup;
    logic [NUM_PADS-1:0] w_pulldown;
    logic [NUM_PADS-1:0] w_drive0;
    logic [NUM_PADS-1:0] w_drive1;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [CFG_BITS-1:0] w_word;
        assign w_word        = r_active[p*CFG_BITS +: CFG_BITS];
        // Protected pads carry the serial interface itself and must stay inputs.
        assign w_oe[p]       = w_word[CFG_OE] & ~PROTECT_MASK[p];
        assign w_ie[p]       = w_word[CFG_IE] |  PROTECT_MASK[p];
        assign w_schmitt[p]  = w_word[CFG_SCHMITT];
        assign w_slew[p]     = w_word[CFG_SLEW];
        assign w_pullup[p]   = w_word[CFG_PULLUP];
        assign w_pulldown[p] = w_word[CFG_PULLDOWN];
        assign w_drive0[p]   = w_word[CFG_DRIVE0];
        assign w_drive1[p]   = w_word[CFG_DRIVE1];
    end

    assign bus.gpio_oe       = w_oe;
    assign bus.gpio_ie       = w_ie;
    assign bus.gpio_schmitt  = w_schmitt;
    assign bus.gpio_slew     = w_slew;
    assign bus.gpio_pullup   = w_pullup;
    assign bus.gpio_pulldown = w_pulldown;
    assign bus.gpio_drive0   = w_drive0;
    assign bus.gpio_drive1   = w_drive1;
    assign bus.gpio_out      = bus.user_out & w_oe;
    assign bus.cfg_busy      = (r_count != '0);
    assign bus.cfg_error     = r_error;
    assign bus.cfg_count     = r_count;

endmodule

// File: tb/tb_openframe_gpio_config.sv
// tb/tb_openframe_gpio_config.sv - self-checking bench for openframe_gpio_config
module tb_openframe_gpio_config;

    import openframe_gpio_pkg::*;

    localparam int               NP   = 44;
    localparam logic [NP-1:0]    PROT = 44'h1;

    logic clock = 1'b0;
    logic resetb;
    always #5 clock = ~clock;

    openframe_gpio_config_if #(.NUM_PADS(NP)) bus ();

    openframe_gpio_config #(
        .NUM_PADS    (NP),
        .CFG_BITS    (8),
        .SYNC_STAGES (2),
        .RESET_CFG   (8'h02),
        .PROTECT_MASK(PROT)
    ) dut (
        .clock (clock),
        .resetb(resetb),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_active [NP];
    logic [7:0] tx_cfg     [NP];

    logic [9*NP-1:0] act_all;
    assign act_all = {bus.gpio_out, bus.gpio_drive1, bus.gpio_drive0, bus.gpio_pulldown,
                      bus.gpio_pullup, bus.gpio_slew, bus.gpio_schmitt, bus.gpio_ie, bus.gpio_oe};

    // Expected pad outputs from the per-pad config bytes and the protect rule.
    function automatic logic [9*NP-1:0] model_all();
        logic [NP-1:0] v [9];
        logic [NP-1:0] prot;
        logic [7:0]    w;
        prot = PROT;
        for (int p = 0; p < NP; p++) begin
            w = exp_active[p];
            v[0][p] = w[0] & ~prot[p];
            v[1][p] = w[1] |  prot[p];
            for (int b = 2; b < 8; b++) v[b][p] = w[b];
            v[8][p] = bus.user_out[p] & v[0][p];
        end
        return {v[8], v[7], v[6], v[5], v[4], v[3], v[2], v[1], v[0]};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic rand_user();
        bus.user_out = NP'({$urandom(), $urandom()});
    endtask

    task automatic fill_tx(input int fixed_pad, input logic [7:0] fixed_word, input bit rnd);
        for (int p = 0; p < NP; p++) tx_cfg[p] = rnd ? 8'($urandom()) : 8'h02;
        if (fixed_pad >= 0) tx_cfg[fixed_pad] = fixed_word;
    endtask

    // Stream is sent most-significant bit (pad 43, bit 7) first.
    task automatic send_bits(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            int pos;
            pos = TOTAL_BITS - 1 - i;
            if (pos >= 0) bus.ser_data = tx_cfg[pos / 8][pos % 8];
            else          bus.ser_data = 1'($urandom_range(1));
            bus.ser_clk = 1'b1;
            cyc(3);
            bus.ser_clk = 1'b0;
            cyc(3);
        end
    endtask

    task automatic pulse_strobe();
        bus.ser_strobe = 1'b1;
        cyc(3);
        bus.ser_strobe = 1'b0;
        cyc(6);
    endtask

    task automatic accept_tx();
        for (int p = 0; p < NP; p++) exp_active[p] = tx_cfg[p];
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        bus.user_out = '1;
        cyc(3);
        resetb = 1'b1;
        cyc(1);
        for (int p = 0; p < NP; p++) exp_active[p] = 8'h02;
        total++; if (act_all !== model_all()) begin bad++; $display("FAIL reset_pads: got %h want %h", act_all, model_all()); end
        total++; if (bus.gpio_ie !== {NP{1'b1}}) begin bad++; $display("FAIL reset_ie: got %h want all ones", bus.gpio_ie); end
        total++; if (bus.gpio_out !== '0) begin bad++; $display("FAIL reset_out: got %h want 0", bus.gpio_out); end
        total++; if (bus.cfg_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", bus.cfg_error); end
        total++; if (bus.cfg_count !== 9'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.cfg_count); end
        total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.cfg_busy); end
    endtask

    task automatic test_full_load();
        fill_tx(5, 8'h41, 1'b0);
        send_bits(TOTAL_BITS);
        total++; if (bus.cfg_count !== 9'd352) begin bad++; $display("FAIL full_count_pre: got %0d want 352", bus.cfg_count); end
        total++; if (bus.cfg_busy !== 1'b1) begin bad++; $display("FAIL full_busy_pre: got %b want 1", bus.cfg_busy); end
        pulse_strobe();
        accept_tx();
        rand_user();
        bus.user_out[5] = 1'b1;
        #1;
        total++; if (act_all !== model_all()) begin bad++; $display("FAIL full_pads: got %h want %h", act_all, model_all()); end
        total++; if (bus.gpio_oe[5] !== 1'b1 || bus.gpio_drive0[5] !== 1'b1) begin bad++; $display("FAIL full_pad5: got oe=%b d0=%b want 1 1", bus.gpio_oe[5], bus.gpio_drive0[5]); end
        total++; if (bus.gpio_out[5] !== 1'b1) begin bad++; $display("FAIL full_out5: got %b want 1", bus.gpio_out[5]); end
        total++; if (bus.cfg_error !== 1'b0 || bus.cfg_count !== 9'd0) begin bad++; $display("FAIL full_status: got err=%b cnt=%0d want 0 0", bus.cfg_error, bus.cfg_count); end
        // Random contents
        fill_tx(-1, 8'h00, 1'b1);
        send_bits(TOTAL_BITS);
        pulse_strobe();
        accept_tx();
        rand_user();
        #1;
        total++; if (act_all !== model_all()) begin bad++; $display("FAIL rand_pads: got %h want %h", act_all, model_all()); end
    endtask

    task automatic test_short_load();
        fill_tx(-1, 8'h00, 1'b1);
        send_bits(TOTAL_BITS - 1);
        total++; if (bus.cfg_count !== 9'd351) begin bad++; $display("FAIL short_count_pre: got %0d want 351", bus.cfg_count); end
        pulse_strobe();
        total++; if (act_all !== model_all()) begin bad++; $display("FAIL short_unchanged: got %h want %h", act_all, model_all()); end
        total++; if (bus.cfg_error !== 1'b1 || bus.cfg_count !== 9'd0) begin bad++; $display("FAIL short_status: got err=%b cnt=%0d want 1 0", bus.cfg_error, bus.cfg_count); end
        fill_tx(-1, 8'h00, 1'b1);
        send_bits(TOTAL_BITS);
        pulse_strobe();
        accept_tx();
        total++; if (act_all !== model_all()) begin bad++; $display("FAIL recover_pads: got %h want %h", act_all, model_all()); end
        total++; if (bus.cfg_error !== 1'b0) begin bad++; $display("FAIL recover_error: got %b want 0", bus.cfg_error); end
    endtask

    task automatic test_overlong();
        fill_tx(-1, 8'h00, 1'b1);
        send_bits(360);
        total++; if (bus.cfg_count !== 9'd360) begin bad++; $display("FAIL long_count_pre: got %0d want 360", bus.cfg_count); end
        pulse_strobe();
        total++; if (act_all !== model_all()) begin bad++; $display("FAIL long_unchanged: got %h want %h", act_all, model_all()); end
        total++; if (bus.cfg_error !== 1'b1) begin bad++; $display("FAIL long_error: got %b want 1", bus.cfg_error); end
        send_bits(600);
        total++; if (bus.cfg_count !== 9'd511) begin bad++; $display("FAIL sat_count: got %0d want 511", bus.cfg_count); end
        pulse_strobe();
        total++; if (bus.cfg_error !== 1'b1 || bus.cfg_count !== 9'd0) begin bad++; $display("FAIL sat_status: got err=%b cnt=%0d want 1 0", bus.cfg_error, bus.cfg_count); end
        total++; if (act_all !== model_all()) begin bad++; $display("FAIL sat_unchanged: got %h want %h", act_all, model_all()); end
    endtask

    task automatic test_protect();
        fill_tx(0, 8'h01, 1'b1);
        send_bits(TOTAL_BITS);
        pulse_strobe();
        accept_tx();
        bus.user_out = '1;
        #1;
        total++; if (bus.gpio_oe[0] !== 1'b0 || bus.gpio_ie[0] !== 1'b1) begin bad++; $display("FAIL protect_pad0: got oe=%b ie=%b want 0 1", bus.gpio_oe[0], bus.gpio_ie[0]); end
        total++; if (bus.gpio_out[0] !== 1'b0) begin bad++; $display("FAIL protect_out0: got %b want 0", bus.gpio_out[0]); end
        total++; if (act_all !== model_all()) begin bad++; $display("FAIL protect_pads: got %h want %h", act_all, model_all()); end
    endtask

    task automatic test_collision();
        fill_tx(-1, 8'h00, 1'b1);
        send_bits(TOTAL_BITS);
        // Shift clock and strobe rise together: the extra bit must not land.
        bus.ser_data   = 1'($urandom_range(1));
        bus.ser_clk    = 1'b1;
        bus.ser_strobe = 1'b1;
        cyc(3);
        bus.ser_clk    = 1'b0;
        bus.ser_strobe = 1'b0;
        cyc(6);
        accept_tx();
        rand_user();
        #1;
        total++; if (bus.cfg_error !== 1'b0 || bus.cfg_count !== 9'd0) begin bad++; $display("FAIL collide_status: got err=%b cnt=%0d want 0 0", bus.cfg_error, bus.cfg_count); end
        total++; if (act_all !== model_all()) begin bad++; $display("FAIL collide_pads: got %h want %h", act_all, model_all()); end
    endtask

    task automatic test_reset_mid_shift();
        fill_tx(-1, 8'h00, 1'b1);
        send_bits(100);
        total++; if (bus.cfg_count !== 9'd100) begin bad++; $display("FAIL mid_count_pre: got %0d want 100", bus.cfg_count); end
        resetb = 1'b0;
        cyc(2);
        resetb = 1'b1;
        cyc(1);
        for (int p = 0; p < NP; p++) exp_active[p] = 8'h02;
        total++; if (bus.cfg_count !== 9'd0 || bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL mid_count: got cnt=%0d busy=%b want 0 0", bus.cfg_count, bus.cfg_busy); end
        total++; if (act_all !== model_all()) begin bad++; $display("FAIL mid_pads: got %h want %h", act_all, model_all()); end
        pulse_strobe();
        total++; if (bus.cfg_error !== 1'b1) begin bad++; $display("FAIL mid_error: got %b want 1", bus.cfg_error); end
        total++; if (act_all !== model_all()) begin bad++; $display("FAIL mid_default: got %h want %h", act_all, model_all()); end
    endtask

    initial begin
        resetb         = 1'b0;
        bus.ser_clk    = 1'b0;
        bus.ser_data   = 1'b0;
        bus.ser_strobe = 1'b0;
        bus.user_out   = '0;
        cyc(1);
        test_reset();
        test_full_load();
        test_short_load();
        test_overlong();
        test_protect();
        test_collision();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/openframe_gpio_config.md
Name: openframe_gpio_config

Overview:
- Pad-configuration stage inside openframe_user_project. Drives the per-pad control vectors (gpio_oe, gpio_ie, gpio_schmitt, gpio_slew, gpio_pullup, gpio_pulldown, gpio_drive0, gpio_drive1) that the wrapper exports to the padframe.
- Configuration is loaded from a 3-wire serial stream (ser_clk, ser_data, ser_strobe) arriving asynchronously on GPIO inputs.
- Serial bits fill a shadow shift register. A strobe commits the shadow atomically to the active pad configuration.

Parameters:
- NUM_PADS, 44: number of GPIO pads.
- CFG_BITS, 8: configuration bits per pad.
- SYNC_STAGES, 2: synchronizer flops on each serial input.
- RESET_CFG, 8'h02: per-pad reset and default config word (ie=1, all other bits 0).
- PROTECT_MASK, 44'h0: pads forced to oe=0, ie=1 regardless of config (the serial-interface pads).

Ports:
- clock  in  1  core clock
- resetb  in  1  synchronous, active-low reset
- ser_clk  in  1  async serial shift clock (from gpio_in)
- ser_data  in  1  async serial data (from gpio_in)
- ser_strobe  in  1  async commit strobe (from gpio_in)
- user_out  in  NUM_PADS  core output data
- gpio_out  out  NUM_PADS  pad output data
- gpio_oe, gpio_ie, gpio_schmitt, gpio_slew, gpio_pullup, gpio_pulldown, gpio_drive0, gpio_drive1  out  NUM_PADS each  active pad controls
- cfg_busy  out  1  shift in progress (bit count nonzero)
- cfg_error  out  1  sticky; last commit had the wrong bit count
- cfg_count  out  9  bits received since last commit

Behaviour:
- Config word bit layout: [0]oe [1]ie [2]schmitt [3]slew [4]pullup [5]pulldown [6]drive0 [7]drive1.
- Shadow and active registers are each NUM_PADS*CFG_BITS (352) bits; pad p occupies bits [p*8+7:p*8].
- Clock and reset: all flops on rising clock; resetb=0 sampled at an edge resets everything.
- Reset values:
  - active and shadow = RESET_CFG replicated.
  - cfg_count=0, cfg_error=0, cfg_busy=0, state=IDLE, synchronizers=0.
  - Reset mid-shift discards partial data.
- Input path: each serial input passes through SYNC_STAGES flops. ser_clk and ser_strobe also get one edge flop, and a rising edge is detected as sync=1, prev=0. ser_data is delayed so it aligns with the ser_clk edge pulse. Edge pulse appears SYNC_STAGES+1 cycles after the pad transition.
- Shift: on a ser_clk edge pulse, shadow <= {shadow[350:0], ser_data}. The first bit sent ends at bit 351 (pad 43 drive1). cfg_count increments, saturating at 511.
- FSM states:
  - IDLE: count=0. ser_clk edge -> SHIFT. strobe edge -> COMMIT.
  - SHIFT: accepts edges. strobe edge -> COMMIT.
  - COMMIT: lasts one cycle.
    - If cfg_count==352: active <= shadow and cfg_error <= 0.
    - Otherwise: active unchanged and cfg_error <= 1.
    - Then cfg_count <= 0 and state -> IDLE.
    - Edges arriving during COMMIT are dropped.
- Simultaneous ser_clk and strobe edge pulses in the same cycle: strobe wins and the shift edge is discarded.
- Active outputs change exactly one cycle after the strobe edge pulse (registered in COMMIT).
- Outputs:
  - gpio_* come directly from active registers, except pads in PROTECT_MASK, whose oe=0 and ie=1 are forced combinationally.
  - gpio_out = user_out & gpio_oe (combinational).
  - cfg_busy = (cfg_count != 0).
- Shadow is not cleared on commit or error, so the next stream overwrites it by shifting.

Decomposition:
- Package openframe_gpio_pkg holds:
  - bit-position constants CFG_OE..CFG_DRIVE1,
  - CFG_BITS, NUM_PADS, TOTAL_BITS=352,
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module openframe_sync_edge: SYNC_STAGES synchronizer plus rising-edge detect, with outputs sync and rise. Instantiated for ser_clk, ser_data and ser_strobe (ser_data uses sync only).

Test Plan:
- Reset: hold resetb=0 for 3 cycles -> every gpio_ie=1, every other control 0, gpio_out=0 for any user_out, cfg_error=0, cfg_count=0.
- Full load: shift 352 bits with pad 5 word 8'h41 (oe, drive0) and all other pads 8'h02, then strobe -> one cycle after the strobe edge pulse gpio_oe[5]=1 and gpio_drive0[5]=1; user_out[5]=1 -> gpio_out[5]=1; cfg_error=0.
- Short load: shift 351 bits, then strobe -> active unchanged, cfg_error=1, cfg_count=0. A subsequent correct 352-bit load clears cfg_error.
- Overlong load: 360 bits, then strobe -> cfg_error=1, no change. Count saturation: 600 edges -> cfg_count holds 511.
- Protect and collision: PROTECT_MASK bit 0 set and 8'h01 loaded for pad 0 -> gpio_oe[0]=0, gpio_ie[0]=1. Separately, ser_clk and ser_strobe edges in the same cycle -> commit occurs and that bit is not shifted.
- Reset mid-shift after 100 bits -> cfg_count=0, shadow=default; a following strobe sets cfg_error=1 and leaves active at default.
